// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO: show-ahead read, optional overwrite-when-full,
// almost flags, synchronous flush and registered overflow/underflow pulses.

module fifo_param_checker #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 5
) (
  input logic          clk,
  input logic          rst_n,
  input logic          clear,
  input logic [CW-1:0] count,
  input logic [AW-1:0] waddr,
  input logic [AW-1:0] raddr
);

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    int'(count) <= DEPTH);

  a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(waddr) < DEPTH) && (int'(raddr) < DEPTH));

  // Occupancy must agree with pointer distance; equal pointers mean empty or full.
  a_count_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(count) == ((int'(waddr) - int'(raddr) + DEPTH) % DEPTH)) ||
    ((int'(count) == DEPTH) && (waddr == raddr)));

  a_count_step: assert property (@(posedge clk) disable iff (!rst_n)
    $past(clear) || (int'(count) == int'($past(count))) ||
    (int'(count) == int'($past(count)) + 1) || (int'(count) + 1 == int'($past(count))));

  a_waddr_step: assert property (@(posedge clk) disable iff (!rst_n)
    (waddr == $past(waddr)) || (int'(waddr) == 0) || (int'(waddr) == int'($past(waddr)) + 1));

  a_raddr_step: assert property (@(posedge clk) disable iff (!rst_n)
    (raddr == $past(raddr)) || (int'(raddr) == 0) || (int'(raddr) == int'($past(raddr)) + 1));

endmodule

module fifo_param #(
  parameter int  WIDTH     = 8,
  parameter int  DEPTH     = 16,
  parameter bit  OVERWRITE = 1'b1,
  parameter int  AFULL_TH  = DEPTH - 2,
  parameter int  AEMPTY_TH = 2,
  localparam int AW        = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    waddr_r;
  logic [AW-1:0]    raddr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             is_empty_s;
  logic             is_full_s;
  logic             wr_s;
  logic             rd_s;
  logic             ovf_s;
  logic             unf_s;

  // Wrap explicitly so non-power-of-two depths never reach DEPTH.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      ptr_inc = {AW{1'b0}};
    end else begin
      ptr_inc = p + AW'(1'b1);
    end
  endfunction

  assign is_empty_s = (count_r == {CW{1'b0}});
  assign is_full_s  = (count_r == CW'(DEPTH));

  // Decide which pointer moves this cycle and whether an error event occurs.
  always_comb begin
    wr_s  = 1'b0;
    rd_s  = 1'b0;
    ovf_s = 1'b0;
    unf_s = 1'b0;
    if (clear) begin
      wr_s = 1'b0;
    end else if (is_full_s) begin
      if (wen && !ren) begin
        ovf_s = 1'b1;
        wr_s  = OVERWRITE;
        rd_s  = OVERWRITE;
      end else begin
        wr_s = wen;
        rd_s = ren;
      end
    end else if (is_empty_s) begin
      wr_s  = wen;
      unf_s = ren;
    end else begin
      wr_s = wen;
      rd_s = ren;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_r <= {AW{1'b0}};
      raddr_r <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      waddr_r <= {AW{1'b0}};
      raddr_r <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (wr_s) begin
        waddr_r <= ptr_inc(waddr_r);
      end
      if (rd_s) begin
        raddr_r <= ptr_inc(raddr_r);
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[waddr_r] <= wdata;
    end
  end

  // Error pulses, one cycle after the offending cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= ovf_s;
      underflow_r <= unf_s;
    end
  end

  assign rdata        = mem_r[raddr_r];
  assign count        = count_r;
  assign full         = is_full_s;
  assign empty        = rst_n & is_empty_s;
  assign almost_full  = (int'(count_r) >= AFULL_TH);
  assign almost_empty = rst_n & (int'(count_r) <= AEMPTY_TH);
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

  fifo_param_checker #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) u_checker (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .count (count_r),
    .waddr (waddr_r),
    .raddr (raddr_r)
  );

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: three instances (depth 4 overwrite, depth 4 drop,
// depth 5 overwrite) share stimulus and are checked against a queue model.

module tb_fifo_param;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n, clear, wen, ren;
  logic [7:0] wdata;

  logic [7:0] rdata_a, rdata_b, rdata_c;
  logic [2:0] count_a, count_b, count_c;
  logic full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic full_c, empty_c, af_c, ae_c, ovf_c, unf_c;

  byte_q_t qa, qb, qc;
  bit      mova, muna, movb, munb, movc, munc;
  int      total = 0;
  int      bad   = 0;

  always #5 clk = ~clk;

  fifo_param #(.WIDTH(8), .DEPTH(4), .OVERWRITE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata_a), .count(count_a), .full(full_a), .empty(empty_a),
    .almost_full(af_a), .almost_empty(ae_a), .overflow(ovf_a), .underflow(unf_a));

  fifo_param #(.WIDTH(8), .DEPTH(4), .OVERWRITE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata_b), .count(count_b), .full(full_b), .empty(empty_b),
    .almost_full(af_b), .almost_empty(ae_b), .overflow(ovf_b), .underflow(unf_b));

  fifo_param #(.WIDTH(8), .DEPTH(5), .OVERWRITE(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata_c), .count(count_c), .full(full_c), .empty(empty_c),
    .almost_full(af_c), .almost_empty(ae_c), .overflow(ovf_c), .underflow(unf_c));

  wire [29:0] st_all = {1'b0, count_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a,
                        1'b0, count_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b,
                        1'b0, count_c, full_c, empty_c, af_c, ae_c, ovf_c, unf_c};

  // Reference: a FIFO is an ordered list of words with the documented full/empty rules.
  task automatic model_step(input int depth, input bit ow, input byte_q_t qi,
                            output byte_q_t qo, output bit ovf, output bit unf);
    byte_q_t q;
    int n;
    q = qi;
    n = q.size();
    ovf = 1'b0;
    unf = 1'b0;
    if (clear) begin
      q.delete();
    end else if (n == 0) begin
      unf = ren;
      if (wen) q.push_back(wdata);
    end else if (n == depth) begin
      if (wen && !ren) begin
        ovf = 1'b1;
        if (ow) begin
          void'(q.pop_front());
          q.push_back(wdata);
        end
      end else if (ren) begin
        void'(q.pop_front());
        if (wen) q.push_back(wdata);
      end
    end else begin
      if (ren) void'(q.pop_front());
      if (wen) q.push_back(wdata);
    end
    qo = q;
  endtask

  function automatic logic [9:0] stat_exp(int n, int depth, bit ovf, bit unf);
    logic [3:0] c;
    c = 4'(n);
    return {c, n == depth, n == 0, n >= depth - 2, n <= 2, ovf, unf};
  endfunction

  function automatic logic [29:0] exp_all();
    return {stat_exp(qa.size(), 4, mova, muna),
            stat_exp(qb.size(), 4, movb, munb),
            stat_exp(qc.size(), 5, movc, munc)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(4, 1'b1, qa, qa, mova, muna);
    model_step(4, 1'b0, qb, qb, movb, munb);
    model_step(5, 1'b1, qc, qc, movc, munc);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; wen = 1'b0; ren = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); wdata = 8'h00;
    #3;
    total++;
    if (st_all !== 30'h0) begin
      bad++; $display("FAIL reset_low got=%h want=%h", st_all, 30'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    total++;
    if (st_all !== exp_all()) begin
      bad++; $display("FAIL reset_release got=%h want=%h", st_all, exp_all());
    end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; wdata = vals[i];
      tick();
      total++;
      if (st_all !== exp_all()) begin
        bad++; $display("FAIL fill_status[%0d] got=%h want=%h", i, st_all, exp_all());
      end
      total++;
      if (rdata_a !== 8'h11 || rdata_b !== 8'h11) begin
        bad++; $display("FAIL fill_rdata[%0d] got=%h/%h want=11", i, rdata_a, rdata_b);
      end
    end
    total++;
    if (full_a !== 1'b1 || count_a !== 3'd4) begin
      bad++; $display("FAIL fill_full got=%b/%0d want=1/4", full_a, count_a);
    end
    idle();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_a [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    wen = 1'b1; wdata = 8'h55;
    tick();
    total++;
    if (st_all !== exp_all() || ovf_a !== 1'b1 || ovf_b !== 1'b1) begin
      bad++; $display("FAIL ovf_pulse got=%h want=%h", st_all, exp_all());
    end
    idle();
    tick();
    total++;
    if (st_all !== exp_all() || ovf_a !== 1'b0) begin
      bad++; $display("FAIL ovf_clears got=%h want=%h", st_all, exp_all());
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rdata_a !== exp_a[i] || rdata_b !== exp_b[i]) begin
        bad++; $display("FAIL ovf_read[%0d] got=%h/%h want=%h/%h", i, rdata_a, rdata_b, exp_a[i], exp_b[i]);
      end
      ren = 1'b1;
      tick();
      total++;
      if (st_all !== exp_all()) begin
        bad++; $display("FAIL ovf_read_status[%0d] got=%h want=%h", i, st_all, exp_all());
      end
    end
    idle();
    total++;
    if (empty_a !== 1'b1 || empty_b !== 1'b1) begin
      bad++; $display("FAIL ovf_empty got=%b/%b want=1/1", empty_a, empty_b);
    end
  endtask

  task automatic test_underflow();
    clear = 1'b1; tick(); idle();
    ren = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (st_all !== exp_all() || unf_a !== 1'b1) begin
        bad++; $display("FAIL unf_pulse[%0d] got=%h want=%h", i, st_all, exp_all());
      end
    end
    idle(); tick();
    total++;
    if (st_all !== exp_all() || unf_a !== 1'b0) begin
      bad++; $display("FAIL unf_clears got=%h want=%h", st_all, exp_all());
    end
    wen = 1'b1; ren = 1'b1; wdata = 8'hAA;
    tick(); idle();
    total++;
    if (st_all !== exp_all() || count_a !== 3'd1 || unf_a !== 1'b1) begin
      bad++; $display("FAIL unf_wr_rd got=%h want=%h", st_all, exp_all());
    end
    total++;
    if (rdata_a !== 8'hAA || rdata_b !== 8'hAA || rdata_c !== 8'hAA) begin
      bad++; $display("FAIL unf_wr_rd_data got=%h/%h/%h want=aa", rdata_a, rdata_b, rdata_c);
    end
  endtask

  task automatic test_wrap();
    clear = 1'b1; tick(); idle();
    wen = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wdata = 8'($urandom); tick();
    end
    ren = 1'b1;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (rdata_c !== qc[0]) begin
        bad++; $display("FAIL wrap_rdata[%0d] got=%h want=%h", i, rdata_c, qc[0]);
      end
      wdata = 8'($urandom);
      tick();
      total++;
      if (st_all !== exp_all() || count_c !== 3'd2) begin
        bad++; $display("FAIL wrap_status[%0d] got=%h want=%h", i, st_all, exp_all());
      end
    end
    idle();
  endtask

  task automatic test_clear();
    clear = 1'b1; tick(); idle();
    wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = 8'($urandom); tick();
    end
    clear = 1'b1; wdata = 8'($urandom);
    tick(); idle();
    total++;
    if (st_all !== exp_all() || empty_a !== 1'b1 || count_c !== 3'd0) begin
      bad++; $display("FAIL clear_wen got=%h want=%h", st_all, exp_all());
    end
  endtask

  task automatic test_async_reset();
    wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wdata = 8'($urandom); tick();
    end
    idle();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (st_all !== 30'h0) begin
      bad++; $display("FAIL async_reset got=%h want=%h", st_all, 30'h0);
    end
    qa.delete(); qb.delete(); qc.delete();
    mova = 1'b0; muna = 1'b0; movb = 1'b0; munb = 1'b0; movc = 1'b0; munc = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (st_all !== exp_all()) begin
      bad++; $display("FAIL async_release got=%h want=%h", st_all, exp_all());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      clear = ($urandom_range(0, 39) == 0);
      wen   = 1'($urandom_range(0, 1));
      ren   = 1'($urandom_range(0, 1));
      wdata = 8'($urandom);
      if (qa.size() > 0) begin
        total++;
        if (rdata_a !== qa[0]) begin
          bad++; $display("FAIL rand_rdata_a[%0d] got=%h want=%h", i, rdata_a, qa[0]);
        end
      end
      if (qb.size() > 0) begin
        total++;
        if (rdata_b !== qb[0]) begin
          bad++; $display("FAIL rand_rdata_b[%0d] got=%h want=%h", i, rdata_b, qb[0]);
        end
      end
      if (qc.size() > 0) begin
        total++;
        if (rdata_c !== qc[0]) begin
          bad++; $display("FAIL rand_rdata_c[%0d] got=%h want=%h", i, rdata_c, qc[0]);
        end
      end
      tick();
      total++;
      if (st_all !== exp_all()) begin
        bad++; $display("FAIL rand_status[%0d] got=%h want=%h", i, st_all, exp_all());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_wrap();
    test_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
